// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream loader that fills instruction memory, then releases the core
module instr_loader #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS) + 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_len_lo;
  logic [IDX_W-1:0] r_last_idx;
  logic [IDX_W-1:0] r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_buf;
  logic             r_imem_we;
  logic [31:0]      r_imem_addr;
  logic [31:0]      r_imem_wdata;

  logic        w_rx_state;
  logic        w_accept;
  logic [31:0] w_len;
  logic        w_len_bad;
  logic        w_word_end;
  logic        w_last_word;

  assign w_rx_state  = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
  // rst only gates the visible handshake; flops are already held by the async reset.
  assign w_accept    = in_valid && w_rx_state;
  assign w_len       = {16'd0, in_data, r_len_lo};
  assign w_len_bad   = (w_len == 32'd0) || (w_len > DEPTH_U);
  assign w_word_end  = (r_byte_idx == 2'd3);
  assign w_last_word = (r_word_idx == r_last_idx);

  assign in_ready   = rst && w_rx_state;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  // The final word's write cycle is already in DONE; release waits until it retires.
  assign core_rst   = (r_state == S_DONE) && !r_imem_we;
  assign done       = (r_state == S_DONE) && !r_imem_we;
  assign err        = (r_state == S_ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LEN0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN0: if (w_accept) w_next = S_LEN1;
      S_LEN1: if (w_accept) w_next = w_len_bad ? S_ERR : S_DATA;
      S_DATA: if (w_accept && w_word_end && w_last_word) w_next = S_DONE;
      S_DONE: if (reload) w_next = S_LEN0;
      S_ERR:  w_next = S_ERR;
      default: w_next = S_LEN0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len_lo     <= 8'd0;
      r_last_idx   <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= 2'd0;
      r_buf        <= 24'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= 32'd0;
      r_imem_wdata <= 32'd0;
    end else begin
      r_imem_we <= 1'b0;
      if (r_state == S_LEN0 && w_accept) begin
        r_len_lo <= in_data;
      end
      if (r_state == S_LEN1 && w_accept) begin
        r_last_idx <= IDX_W'(w_len - 32'd1);
        r_word_idx <= '0;
        r_byte_idx <= 2'd0;
      end
      if (r_state == S_DATA && w_accept) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0: r_buf[7:0]   <= in_data;
          2'd1: r_buf[15:8]  <= in_data;
          2'd2: r_buf[23:16] <= in_data;
          default: begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= 32'({r_word_idx, 2'b00});
            r_imem_wdata <= {in_data, r_buf};
            if (!w_last_word) r_word_idx <= r_word_idx + 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - vector table plus write scoreboard for instr_loader
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  nbytes;
    logic [79:0] bytes;
    logic        toggle;
    logic [1:0]  nwr;
    logic [63:0] wdata;
    logic        exp_err;
  } vec_t;

  logic [63:0] sb_q[$];

  instr_loader #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && imem_we) begin
      logic [63:0] e;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=0x%08h@0x%08h required=none", imem_wdata, imem_addr);
      end else begin
        e = sb_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          failures++;
          $display("FAIL write actual=0x%08h@0x%08h required=0x%08h@0x%08h",
                   imem_wdata, imem_addr, e[31:0], e[63:32]);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outs", {26'd0, imem_we, core_rst, done, err, 2'b00}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready0 required=in_ready1");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] bs[], input bit toggle);
    foreach (bs[i]) begin
      if (toggle && i > 0) begin
        @(posedge clk); #1;
      end
      send_byte(bs[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{4'd10, 80'h0200_1305_A000_9305_B000, 1'b0, 2'd2, 64'h00A00513_00B00593, 1'b0};
    vecs[1] = '{4'd10, 80'h0200_1305_A000_9305_B000, 1'b1, 2'd2, 64'h00A00513_00B00593, 1'b0};
    vecs[2] = '{4'd2,  80'h0000_0000_0000_0000_0000, 1'b0, 2'd0, 64'd0, 1'b1};
    vecs[3] = '{4'd2,  80'h0104_0000_0000_0000_0000, 1'b0, 2'd0, 64'd0, 1'b1};

    foreach (vecs[v]) begin
      vec_t vv;
      vv = vecs[v];
      do_reset();
      for (int i = 0; i < int'(vv.nbytes); i++) begin
        logic [79:0] bb;
        logic [7:0]  b;
        int d;
        bb = vv.bytes;
        b  = bb[79-8*i -: 8];
        d  = i - 2;
        if (d >= 0 && (d % 4) == 3) begin
          logic [63:0] wd;
          wd = vv.wdata;
          sb_q.push_back({32'(4 * (d / 4)), (d / 4 == 0) ? wd[63:32] : wd[31:0]});
        end
        if (vv.toggle && i > 0) begin
          @(posedge clk); #1;
        end
        send_byte(b);
      end
      if (vv.exp_err) begin
        check("err_flag", 32'(err), 32'd1);
        check("err_in_ready", 32'(in_ready), 32'd0);
        check("err_core_rst", 32'(core_rst), 32'd0);
        idle(3);
        check("err_hold", {29'd0, err, core_rst, in_ready}, 32'h4);
      end else begin
        check("last_we_cycle", {28'd0, imem_we, in_ready, core_rst, done}, 32'h8);
        idle(1);
        check("released", {28'd0, imem_we, in_ready, core_rst, done}, 32'h3);
        check("no_err", 32'(err), 32'd0);
      end
      check("sb_empty", 32'(sb_q.size()), 32'd0);
    end

    // reset midway through word 0, then a fresh single-word load
    do_reset();
    send_stream('{8'h02, 8'h00, 8'h11, 8'h22}, 1'b0);
    #3 rst = 1'b0;
    #1;
    check("async_rst_ready", 32'(in_ready), 32'd0);
    check("async_rst_outs", {28'd0, imem_we, core_rst, done, err}, 32'd0);
    idle(1);
    rst = 1'b1;
    #1;
    sb_q.push_back({32'h0, 32'hDEADBEEF});
    send_stream('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b0);
    idle(1);
    check("midrst_done", {30'd0, core_rst, done}, 32'h3);
    check("midrst_sb", 32'(sb_q.size()), 32'd0);

    // bytes offered in DONE are refused
    in_valid = 1'b1; in_data = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("done_refuse", {30'd0, in_ready, done}, 32'h1);
    end
    in_valid = 1'b0;

    // reload starts a new load and holds the core in reset during it
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("reload_state", {29'd0, in_ready, core_rst, done}, 32'h4);
    sb_q.push_back({32'h0, 32'h12345678});
    send_stream('{8'h01, 8'h00, 8'h78, 8'h56}, 1'b0);
    check("reload_core_rst", 32'(core_rst), 32'd0);
    send_stream('{8'h34, 8'h12}, 1'b0);
    idle(1);
    check("reload_done", {30'd0, core_rst, done}, 32'h3);
    check("reload_sb", 32'(sb_q.size()), 32'd0);

    // reload is ignored in ERR
    do_reset();
    send_stream('{8'h00, 8'h00}, 1'b0);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    idle(1);
    check("err_reload", {30'd0, err, in_ready}, 32'h2);

    // N == DEPTH_WORDS is a legal length
    do_reset();
    send_stream('{8'h00, 8'h04}, 1'b0);
    check("max_len_ok", {30'd0, err, in_ready}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, instruction-memory capacity in 32-bit words.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  byte-stream source has a byte.
REQ-005 in_data  input  8  stream byte.
REQ-006 in_ready  output  1  loader accepts byte; transfer when in_valid & in_ready at edge.
REQ-007 reload  input  1  single-cycle request to start a new load; honoured only in DONE.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  32  byte address of word written, word-aligned (PC-compatible).
REQ-010 imem_wdata  output  32  word written.
REQ-011 core_rst  output  1  active-low reset to core; 0 holds core in reset.
REQ-012 done  output  1  load complete, core released.
REQ-013 err  output  1  invalid length received.

Function
REQ-014 States: LEN0, LEN1, DATA, DONE, ERR; reset enters LEN0.
REQ-015 Stream format: 16-bit word count N (low byte first), then 4*N bytes, each word little-endian (first byte -> bits 7:0).
REQ-016 in_ready = 1 in LEN0, LEN1, DATA; 0 in DONE and ERR.
REQ-017 LEN0: accepted byte -> N[7:0]; go LEN1.
REQ-018 LEN1: accepted byte -> N[15:8]; if N==0 or N>DEPTH_WORDS go ERR, else go DATA with word index 0, byte index 0.
REQ-019 DATA: each accepted byte shifts into word buffer at position byte index; byte index wraps 3->0.
REQ-020 On acceptance of 4th byte of word k: next cycle imem_we=1, imem_addr=4*k, imem_wdata=assembled word, exactly one cycle.
REQ-021 in_ready remains 1 during the write cycle; a byte accepted that cycle belongs to word k+1 (no bubbles required).
REQ-022 After the 4th byte of word N-1 is accepted, state becomes DONE coincident with that word's imem_we cycle; in_ready drops that cycle.
REQ-023 core_rst = 0 in all states except DONE; core_rst, done = 1 from the cycle after the last imem_we pulse.
REQ-024 imem_we never asserts outside DATA-originated writes; imem_addr/imem_wdata hold last written values when imem_we=0.
REQ-025 Word index width ceil(log2(DEPTH_WORDS))+1; index never exceeds N-1; no address wrap.
REQ-026 DONE + reload=1: go LEN0, core_rst=0 and done=0 next cycle; imem contents not cleared.
REQ-027 reload ignored in LEN0, LEN1, DATA, ERR.
REQ-028 ERR: err=1, in_ready=0, core_rst=0, imem_we=0; exits only via rst.
REQ-029 in_valid=0 stalls indefinitely in any receive state without state or index change.

Reset
REQ-030 rst low (any state, including mid-word or mid-load) immediately: state LEN0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, done=0, err=0, indices 0, in_ready=0 while rst low.
REQ-031 After rst release, in_ready=1 from the first rising edge; partially loaded words are discarded, not written.

Verification
REQ-032 Bytes 02 00 13 05 A0 00 93 05 B0 00, in_valid always 1 -> imem_we pulses: addr 0x0 data 0x00A00513, addr 0x4 data 0x00B00593; core_rst=1, done=1 one cycle after second pulse.
REQ-033 Same stream with in_valid toggled 1/0 each cycle -> identical writes and data; no extra imem_we pulses.
REQ-034 Length bytes 00 00 -> err=1, in_ready=0, core_rst=0, no imem_we; length 01 04 (1025) with DEPTH_WORDS=1024 -> same.
REQ-035 rst asserted after 2 data bytes of word 0, then stream 01 00 EF BE AD DE -> single write addr 0x0 data 0xDEADBEEF, done=1.
REQ-036 After DONE, pulse reload then stream 01 00 78 56 34 12 -> core_rst 0 during load, write addr 0x0 data 0x12345678, core_rst returns to 1.
REQ-037 Bytes offered while in DONE -> in_ready=0, no writes, state unchanged.
